bp_fe_cmd_sequencer: RTL
========================

Name: bp_fe_cmd_sequencer

Overview:
- Sits between the BE→FE command queue and the FE PC generator.
- Accepts one FE command at a time and registers it.
- Sequences fence commands through the I$/ITLB fence handshake before presenting them to the PC generator; all other commands are forwarded after one cycle.
- Enforces a post-redirect drain window so the PC generator pipeline settles before the next command arrives.

Parameters:
- vaddr_width_p, 39, virtual address width of command vaddr.
- operands_width_p, 64, width of the opaque command operand payload (passed through unmodified).
- drain_cycles_p, 2, idle cycles enforced after any non-attaboy command is presented; 0 disables the window.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  reset, asynchronous, active-high.
- fe_cmd_opcode_i  in  3  opcode, encoded per bp_fe_command_queue_opcodes_e.
- fe_cmd_vaddr_i  in  vaddr_width_p  command target vaddr.
- fe_cmd_operands_i  in  operands_width_p  command operand payload.
- fe_cmd_v_i  in  1  command valid.
- fe_cmd_yumi_o  out  1  command consumed this cycle.
- pcg_cmd_opcode_o  out  3  registered opcode to the PC generator.
- pcg_cmd_vaddr_o  out  vaddr_width_p  registered vaddr.
- pcg_cmd_operands_o  out  operands_width_p  registered operands.
- pcg_cmd_v_o  out  1  single-cycle command pulse. The PC generator always accepts.
- fence_req_v_o  out  1  fence request to the I$/ITLB controller.
- fence_req_itlb_o  out  1  fence type: 1 = ITLB fence, 0 = I$ fence.
- fence_req_yumi_i  in  1  fence request accepted.
- fence_done_i  in  1  fence complete, one-cycle pulse.
- busy_o  out  1  high when state != e_idle or drain count != 0.

Behaviour:
- Reset (async): state = e_idle; drain count = 0; command register = 0.
- Reset outputs: pcg_cmd_v_o, fence_req_v_o, fence_req_itlb_o, fe_cmd_yumi_o and busy_o are all 0.
- Reset mid-fence abandons the fence without a pcg pulse.
- States (2-bit enum): e_idle, e_fence_req, e_fence_wait, e_send.
- fe_cmd_yumi_o = fe_cmd_v_i & (state == e_idle) & (drain count == 0).
- On yumi, the opcode, vaddr and operands are captured into the command register.
- e_idle → e_fence_req on yumi of icache_fence or itlb_fence.
- e_idle → e_send on yumi of any other opcode.
- e_fence_req:
  - fence_req_v_o = 1; fence_req_itlb_o = (captured opcode == itlb_fence).
  - Inputs must stay stable until fence_req_yumi_i.
  - On yumi: go to e_fence_wait, or straight to e_send if fence_done_i is asserted in the same cycle.
- e_fence_wait: → e_send on fence_done_i. fence_done_i is ignored in every other state.
- e_send:
  - pcg_cmd_v_o = 1 for exactly one cycle, with the register contents on the pcg_cmd_* outputs; then → e_idle.
  - If the captured opcode != attaboy, the drain count loads drain_cycles_p on this cycle.
- Drain count decrements by 1 per cycle while nonzero and saturates at 0. The count width is clog2(drain_cycles_p+1), minimum 1 bit.
- Latency (yumi at cycle N):
  - Non-fence command: pcg_cmd_v_o at N+1.
  - Fence command: earliest pcg_cmd_v_o at N+2 (yumi and done both at N+1).
- Throughput:
  - Back-to-back attaboys: one per 2 cycles.
  - Redirects: one per 2+drain_cycles_p cycles.
- pcg_cmd_* data outputs hold the last captured command when pcg_cmd_v_o = 0. Only the valid is a pulse.
- No command preemption: a state_reset arriving during a fence waits in the queue.

Decomposition:
- Shared package (bp_fe_pkg): the state enum bp_fe_cmd_seq_state_e.
- Opcode encodings come from the existing bp_fe_command_queue_opcodes_e; no new copy.
- Drain down-counter: bsg_counter_set_down, instantiated inline.
- Command register: bsg_dff_reset_en with async-reset variant.
- No custom sub-module; the FSM is local.

Test Plan (drain_cycles_p=2, vaddr_width_p=39):
1. Reset pulse mid-e_fence_wait → all outputs 0 immediately, state e_idle; a subsequent pc_redirection is accepted 1 cycle after reset deasserts.
2. pc_redirection, vaddr=0x80000124, held valid for 6 cycles → yumi at N, pcg_cmd_v_o=1 with vaddr 0x80000124 at N+1, busy_o through N+3, next yumi at N+4.
3. Two back-to-back attaboys → yumi at N and N+2, pulses at N+1 and N+3, no drain cycles.
4. icache_fence, vaddr=0x1000; fence_req_yumi_i at N+3; fence_done_i at N+6 → fence_req_v_o=1 and fence_req_itlb_o=0 over N+1..N+3, pcg pulse at N+7, next yumi no earlier than N+10.
5. itlb_fence with yumi and done both at N+1 → fence_req_itlb_o=1, pcg pulse at N+2; a stray fence_done_i at N+5 in e_idle has no effect.
6. state_reset presented while an icache_fence is in e_fence_wait → no yumi until fence completes and the drain window expires; state_reset then forwarded with its vaddr unchanged.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// rtl/bp_fe_pkg.sv - FE shared types: command queue opcodes and command sequencer state
//
// Purpose: types shared by the front-end command path.
//   bp_fe_command_queue_opcodes_e : 3-bit BE->FE command opcode encoding
//   bp_fe_cmd_seq_state_e         : 2-bit command sequencer FSM state
//   is_fence_op()                 : true for opcodes that need the I$/ITLB fence handshake
package bp_fe_pkg;

    typedef enum logic [2:0] {
        e_op_state_reset         = 3'd0,
        e_op_pc_redirection      = 3'd1,
        e_op_icache_fill_response = 3'd2,
        e_op_icache_fence        = 3'd3,
        e_op_itlb_fill_response  = 3'd4,
        e_op_itlb_fence          = 3'd5,
        e_op_attaboy             = 3'd6,
        e_op_wait                = 3'd7
    } bp_fe_command_queue_opcodes_e;

    typedef enum logic [1:0] {
        e_idle       = 2'd0,
        e_fence_req  = 2'd1,
        e_fence_wait = 2'd2,
        e_send       = 2'd3
    } bp_fe_cmd_seq_state_e;

    function automatic logic is_fence_op(input logic [2:0] op);
        return (op == e_op_icache_fence) || (op == e_op_itlb_fence);
    endfunction

endpackage

// File: rtl/bsg_counter_set_down.sv
// rtl/bsg_counter_set_down.sv - loadable down-counter with asynchronous active-high reset
//
// Purpose: loads val_i on set_i, otherwise decrements by one on down_i. Set wins over down.
// The caller is responsible for not asserting down_i at zero.
// Ports:
//   clk_i, reset_i : clock, async active-high reset (count -> 0)
//   set_i, val_i   : load request and load value
//   down_i         : decrement request
//   count_r_o      : current count
module bsg_counter_set_down #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               set_i,
    input  logic [width_p-1:0] val_i,
    input  logic               down_i,
    output logic [width_p-1:0] count_r_o
);

    localparam logic [width_p-1:0] one_lp = width_p'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r_o <= '0;
        end else if (set_i) begin
            count_r_o <= val_i;
        end else if (down_i) begin
            count_r_o <= count_r_o - one_lp;
        end
    end

endmodule

// File: rtl/bsg_dff_reset_en.sv
// rtl/bsg_dff_reset_en.sv - enabled register with asynchronous active-high reset to zero
//
// Purpose: width_p-bit register, loads data_i when en_i, clears asynchronously on reset_i.
// Ports:
//   clk_i, reset_i : clock, async active-high reset
//   en_i           : load enable
//   data_i         : next value
//   data_o         : registered value
module bsg_dff_reset_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_o <= '0;
        end else if (en_i) begin
            data_o <= data_i;
        end
    end

endmodule

// File: rtl/bp_fe_cmd_sequencer.sv
// rtl/bp_fe_cmd_sequencer.sv - FE command sequencer between BE->FE command queue and PC generator
//
// Purpose: accepts one FE command at a time, runs fence commands through the I$/ITLB
// fence handshake, then presents every command to the PC generator as a one-cycle pulse.
// After any non-attaboy command a drain window of drain_cycles_p idle cycles is enforced.
// Ports:
//   clk_i, reset_i          : clock, async active-high reset
//   fe_cmd_*_i, fe_cmd_v_i  : incoming command and valid
//   fe_cmd_yumi_o           : command consumed this cycle
//   pcg_cmd_*_o             : registered command to the PC generator (held between pulses)
//   pcg_cmd_v_o             : one-cycle command pulse
//   fence_req_v_o/itlb_o    : fence request and type (1 = ITLB, 0 = I$)
//   fence_req_yumi_i        : fence request accepted
//   fence_done_i            : fence complete pulse
//   busy_o                  : FSM not idle or drain window active
module bp_fe_cmd_sequencer
    import bp_fe_pkg::*;
#(
    parameter int vaddr_width_p    = 39,
    parameter int operands_width_p = 64,
    parameter int drain_cycles_p   = 2
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic [2:0]                  fe_cmd_opcode_i,
    input  logic [vaddr_width_p-1:0]    fe_cmd_vaddr_i,
    input  logic [operands_width_p-1:0] fe_cmd_operands_i,
    input  logic                        fe_cmd_v_i,
    output logic                        fe_cmd_yumi_o,
    output logic [2:0]                  pcg_cmd_opcode_o,
    output logic [vaddr_width_p-1:0]    pcg_cmd_vaddr_o,
    output logic [operands_width_p-1:0] pcg_cmd_operands_o,
    output logic                        pcg_cmd_v_o,
    output logic                        fence_req_v_o,
    output logic                        fence_req_itlb_o,
    input  logic                        fence_req_yumi_i,
    input  logic                        fence_done_i,
    output logic                        busy_o
);

    localparam int drain_width_lp = (drain_cycles_p < 1) ? 1 : $clog2(drain_cycles_p + 1);
    localparam int cmd_width_lp   = 3 + vaddr_width_p + operands_width_p;
    localparam logic [drain_width_lp-1:0] drain_load_lp = drain_width_lp'(drain_cycles_p);

    bp_fe_cmd_seq_state_e state_r, state_n;

    logic [drain_width_lp-1:0] drain_count;
    logic                      drain_set;
    logic                      drain_active;
    logic                      cmd_yumi;

    logic [cmd_width_lp-1:0]     cmd_r;
    logic [2:0]                  cmd_opcode_r;
    logic [vaddr_width_p-1:0]    cmd_vaddr_r;
    logic [operands_width_p-1:0] cmd_operands_r;

    assign drain_active = (drain_count != '0);

    // Reset is folded in so a command held valid during reset is not consumed
    // while the command register is being cleared.
    assign cmd_yumi      = fe_cmd_v_i & (state_r == e_idle) & ~drain_active & ~reset_i;
    assign fe_cmd_yumi_o = cmd_yumi;

    bsg_dff_reset_en #(
        .width_p (cmd_width_lp)
    ) cmd_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (cmd_yumi),
        .data_i  ({fe_cmd_opcode_i, fe_cmd_vaddr_i, fe_cmd_operands_i}),
        .data_o  (cmd_r)
    );

    assign {cmd_opcode_r, cmd_vaddr_r, cmd_operands_r} = cmd_r;

    // Loaded on the send cycle, so the first drain cycle is the cycle right after the pulse.
    bsg_counter_set_down #(
        .width_p (drain_width_lp)
    ) drain_counter (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .set_i     (drain_set),
        .val_i     (drain_load_lp),
        .down_i    (drain_active),
        .count_r_o (drain_count)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_idle;
        end else begin
            state_r <= state_n;
        end
    end

    always_comb begin
        state_n          = state_r;
        fence_req_v_o    = 1'b0;
        fence_req_itlb_o = 1'b0;
        pcg_cmd_v_o      = 1'b0;
        drain_set        = 1'b0;

        case (state_r)
            e_idle: begin
                if (cmd_yumi) begin
                    state_n = is_fence_op(fe_cmd_opcode_i) ? e_fence_req : e_send;
                end
            end
            e_fence_req: begin
                fence_req_v_o    = 1'b1;
                fence_req_itlb_o = (cmd_opcode_r == e_op_itlb_fence);
                // A controller may accept and finish in the same cycle; skip the wait state then.
                if (fence_req_yumi_i) begin
                    state_n = fence_done_i ? e_send : e_fence_wait;
                end
            end
            e_fence_wait: begin
                if (fence_done_i) begin
                    state_n = e_send;
                end
            end
            e_send: begin
                pcg_cmd_v_o = 1'b1;
                drain_set   = (cmd_opcode_r != e_op_attaboy);
                state_n     = e_idle;
            end
            default: begin
                state_n = e_idle;
            end
        endcase
    end

    assign pcg_cmd_opcode_o   = cmd_opcode_r;
    assign pcg_cmd_vaddr_o    = cmd_vaddr_r;
    assign pcg_cmd_operands_o = cmd_operands_r;

    assign busy_o = (state_r != e_idle) | drain_active;

endmodule
